// File: rtl/npu_avmm_burst_mem.sv
// Avalon-MM burst responder: a read port with a command queue and a pipelined
// data return, and a write port that takes one beat per cycle. Both share one
// word-addressed on-chip memory.
//
// Read engine states
//   RD_IDLE   | nothing streaming; pops the queue head and issues its beat 0
//   RD_STREAM | one memory read per cycle until the last beat of the burst
// Write FSM states
//   WR_IDLE   | waiting for the first beat of a burst (address/length sampled)
//   WR_BURST  | absorbing the remaining beats; address/burstcount ignored
module npu_avmm_burst_mem #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          RD_LATENCY = 2,
  parameter int          CMDQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_s_read,
  input  logic [31:0]           rd_s_address,
  input  logic [4:0]            rd_s_burstcount,
  output logic                  rd_s_waitrequest,
  output logic [DATA_WIDTH-1:0] rd_s_readdata,
  output logic                  rd_s_readdatavalid,
  input  logic                  wr_s_write,
  input  logic [31:0]           wr_s_address,
  input  logic [4:0]            wr_s_burstcount,
  input  logic [DATA_WIDTH-1:0] wr_s_writedata,
  output logic                  wr_s_waitrequest,
  input  logic                  rd_stall,
  input  logic                  wr_stall,
  output logic                  rd_busy,
  output logic                  wr_in_burst,
  output logic                  err_burst,
  input  logic                  err_clr
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);
  localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W    = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(CMDQ_DEPTH + 1);
  // Stages after the synchronous memory read (the last one is the output).
  localparam int          DLY      = RD_LATENCY - 1;

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;
  typedef enum logic {WR_IDLE, WR_BURST}  wr_state_e;

  // Byte address to word index; offset bits drop out, index wraps at MEM_WORDS.
  function automatic logic [IDX_BITS-1:0] word_idx(input logic [31:0] addr);
    return IDX_BITS'((addr - BASE_ADDR) >> OFF_BITS);
  endfunction

  function automatic logic bc_bad(input logic [4:0] bc);
    return (bc == 5'd0) || (bc > 5'd16);
  endfunction

  // Illegal burstcounts still execute, as maximum-length bursts.
  function automatic logic [4:0] bc_len(input logic [4:0] bc);
    return bc_bad(bc) ? 5'd16 : bc;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CMDQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Read command queue
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] q_idx_q [CMDQ_DEPTH];
  logic [4:0]          q_len_q [CMDQ_DEPTH];
  logic [PTR_W-1:0]    q_wptr_q, q_rptr_q;
  logic [CNT_W-1:0]    q_cnt_q;
  logic                q_push, q_pop, q_empty, q_full;
  logic [IDX_BITS-1:0] head_idx;
  logic [4:0]          head_len;

  assign q_empty  = (q_cnt_q == '0);
  assign q_full   = (q_cnt_q == CNT_W'(CMDQ_DEPTH));
  assign head_idx = q_idx_q[q_rptr_q];
  assign head_len = q_len_q[q_rptr_q];

  // Full is judged on the registered count, so a popping full queue still stalls.
  assign rd_s_waitrequest = ~rst_n | rd_stall | q_full;
  assign q_push           = rd_s_read & ~rd_s_waitrequest;

  // Queue payload storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_idx_q[q_wptr_q] <= word_idx(rd_s_address);
      q_len_q[q_wptr_q] <= bc_len(rd_s_burstcount);
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wptr_q <= '0;
      q_rptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (q_push) q_wptr_q <= ptr_inc(q_wptr_q);
      if (q_pop)  q_rptr_q <= ptr_inc(q_rptr_q);
      if (q_push && !q_pop)      q_cnt_q <= q_cnt_q + 1'b1;
      else if (!q_push && q_pop) q_cnt_q <= q_cnt_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rd_state_e           rd_state_q;
  logic [IDX_BITS-1:0] eng_idx_q;   // index issued in the current STREAM cycle
  logic [4:0]          eng_rem_q;   // beats still to issue, including this one
  logic                rd_iss;
  logic [IDX_BITS-1:0] rd_iss_idx;

  // Issue/pop decision: IDLE issues the head's beat 0 directly; STREAM pops the
  // next command while issuing its last beat so the following burst has no gap.
  always_comb begin
    rd_iss     = 1'b0;
    rd_iss_idx = eng_idx_q;
    q_pop      = 1'b0;
    if (rd_state_q == RD_STREAM) begin
      rd_iss = 1'b1;
      if (eng_rem_q == 5'd1 && !q_empty) q_pop = 1'b1;
    end else if (!q_empty) begin
      rd_iss     = 1'b1;
      rd_iss_idx = head_idx;
      q_pop      = 1'b1;
    end
  end

  // Engine state, current beat index and remaining beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      eng_idx_q  <= '0;
      eng_rem_q  <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (!q_empty) begin
            eng_idx_q <= head_idx + 1'b1;
            eng_rem_q <= head_len - 5'd1;
            // A single-beat burst is finished by its issue cycle.
            if (head_len != 5'd1) rd_state_q <= RD_STREAM;
          end
        end
        RD_STREAM: begin
          if (eng_rem_q == 5'd1) begin
            if (!q_empty) begin
              eng_idx_q <= head_idx;
              eng_rem_q <= head_len;
            end else begin
              rd_state_q <= RD_IDLE;
            end
          end else begin
            eng_idx_q <= eng_idx_q + 1'b1;
            eng_rem_q <= eng_rem_q - 5'd1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  wr_state_e           wr_state_q;
  logic [IDX_BITS-1:0] wr_idx_q;
  logic [4:0]          wr_rem_q;
  logic                wr_acc;
  logic [IDX_BITS-1:0] wr_idx_in;
  logic [4:0]          wr_len_in;
  logic [IDX_BITS-1:0] mem_widx;

  assign wr_s_waitrequest = ~rst_n | wr_stall;
  assign wr_acc           = wr_s_write & ~wr_s_waitrequest;
  assign wr_idx_in        = word_idx(wr_s_address);
  assign wr_len_in        = bc_len(wr_s_burstcount);
  assign mem_widx         = (wr_state_q == WR_IDLE) ? wr_idx_in : wr_idx_q;
  assign wr_in_burst      = (wr_state_q == WR_BURST);

  // Burst tracking: first beat latches index/length, later beats count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_rem_q   <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_acc && wr_len_in != 5'd1) begin
            wr_idx_q   <= wr_idx_in + 1'b1;
            wr_rem_q   <= wr_len_in - 5'd1;
            wr_state_q <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (wr_acc) begin
            wr_idx_q <= wr_idx_q + 1'b1;
            wr_rem_q <= wr_rem_q - 5'd1;
            if (wr_rem_q == 5'd1) wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory and read data path
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  iss_vld_q;
  logic [DATA_WIDTH-1:0] dly_data_q [DLY];
  logic [DLY-1:0]        dly_vld_q;

  // Shared array; the read samples the pre-write contents on a same-word hit.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[mem_widx] <= wr_s_writedata;
    if (rd_iss) mem_rdata_q <= mem[rd_iss_idx];
  end

  // Delay line that brings the total command-to-data latency to RD_LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q <= 1'b0;
      dly_vld_q <= '0;
      for (int i = 0; i < DLY; i++) dly_data_q[i] <= '0;
    end else begin
      iss_vld_q    <= rd_iss;
      dly_vld_q[0] <= iss_vld_q;
      if (iss_vld_q) dly_data_q[0] <= mem_rdata_q;
      for (int i = 1; i < DLY; i++) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_data_q[i] <= dly_data_q[i-1];
      end
    end
  end

  assign rd_s_readdatavalid = dly_vld_q[DLY-1];
  assign rd_s_readdata      = dly_data_q[DLY-1];
  assign rd_busy            = ~q_empty | (rd_state_q == RD_STREAM) | iss_vld_q | (|dly_vld_q);

  // ---------------------------------------------------------------------------
  // Sticky burstcount error; a clear wins over a same-cycle set.
  // ---------------------------------------------------------------------------
  logic err_q;
  logic err_set;

  assign err_set   = (q_push & bc_bad(rd_s_burstcount)) |
                     (wr_acc & (wr_state_q == WR_IDLE) & bc_bad(wr_s_burstcount));
  assign err_burst = err_q;

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

endmodule
